svm_mac_sequencer: RTL and testbench
====================================

Name: svm_mac_sequencer

Overview:
Controller that owns the SVM coefficient storage (121 x signed 9-bit, combinational read, registered write). Phase 1 streams host coefficients into storage: entries 0..VEC_LEN-1 are weights and entry VEC_LEN is the bias. Phase 2 walks the storage in lockstep with an incoming feature stream and computes sum(w[i]*x[i]) + bias. It then emits the signed score and the class decision. It sits between the host/feature interfaces and the storage instance, and is the only master of the storage.

Parameters:
DATA_W, 9, width of stored coefficients and features (signed)
ADDR_W, 8, storage address width
VEC_LEN, 120, number of weights; bias at address VEC_LEN; DEPTH = VEC_LEN+1
ACC_W, 25, accumulator/result width (signed); must be >= 2*DATA_W + clog2(DEPTH)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
ld_start  in  1  pulse: begin coefficient load from address 0
ld_valid  in  1  ld_data valid
ld_data  in  DATA_W  coefficient to write
ld_ready  out  1  controller accepts ld_data this cycle
ld_done  out  1  one-cycle pulse after entry VEC_LEN written
cmp_start  in  1  pulse: begin classification
feat_valid  in  1  feat_data valid
feat_data  in  DATA_W  signed feature x[i]
feat_ready  out  1  controller accepts feat_data this cycle
res_valid  out  1  one-cycle pulse: result available
res_data  out  ACC_W  signed score
res_class  out  1  1 when res_data >= 0, else 0
busy  out  1  state != IDLE
mem_addr  out  ADDR_W  storage address
mem_read  out  1  storage read enable
mem_write  out  1  storage write enable
mem_wdata  out  DATA_W  storage write data
mem_rdata  in  DATA_W  storage read data, valid in the same cycle as mem_addr/mem_read

Behaviour:
- Reset: state IDLE, ptr 0, acc 0. All outputs 0: ld_ready, ld_done, feat_ready, res_valid, res_data, res_class, busy, mem_*. Storage contents are not cleared.
- States: IDLE, LOAD, COMPUTE, BIAS, DONE.
- IDLE: mem_read=0, mem_write=0, mem_addr=0.
  - ld_start -> LOAD, ptr<=0.
  - cmp_start -> COMPUTE, ptr<=0, acc<=0.
  - Both in the same cycle: LOAD wins and cmp_start is dropped.
- Starts are ignored while busy=1.
- LOAD:
  - ld_ready=1, mem_addr=ptr, mem_wdata=ld_data.
  - mem_write=ld_valid (combinational), so the storage writes on the same edge.
  - Each accepted beat increments ptr.
  - Beat at ptr==VEC_LEN -> IDLE with ld_done=1 the next cycle.
  - ld_valid low holds ptr; no timeout.
- COMPUTE:
  - mem_read=1, mem_addr=ptr, feat_ready=1.
  - On feat_valid: acc <= acc + sext(mem_rdata*feat_data) (signed 2*DATA_W product), ptr++.
  - feat_valid low: mem_addr and acc hold.
  - Accepted beat at ptr==VEC_LEN-1 -> BIAS.
- BIAS: mem_read=1, mem_addr=VEC_LEN, feat_ready=0; acc <= acc + sext(mem_rdata) -> DONE.
- DONE:
  - res_valid=1 for one cycle; res_data=acc; res_class=~acc[ACC_W-1] -> IDLE.
  - res_data/res_class hold until the next DONE.
- Latency: last feature accepted at edge t -> BIAS during cycle t+1 -> res_valid during cycle t+2. No back-pressure on results.
- Width: products are 18 bits signed. The worst case 120*65536 + 255 fits in 25 bits signed, so no saturation logic is needed.
- rst mid-operation: the next cycle is IDLE with outputs zeroed; no ld_done or res_valid is issued.
  - Interrupted LOAD leaves partially written storage; the host must reload.
- mem_read and mem_write are never both 1.

Decomposition:
- Package svm_pkg holds:
  - constants DATA_W, ADDR_W, VEC_LEN, DEPTH, ACC_W;
  - state enum (IDLE, LOAD, COMPUTE, BIAS, DONE);
  - BIAS_ADDR = VEC_LEN.
- One sub-module, svm_mac: a signed DATA_W x DATA_W multiply-accumulate with clr, en and bias_en (adds sext(a) instead of the product), output ACC_W.
- The FSM, pointer and storage port muxing stay in svm_mac_sequencer.

Test Plan:
1. Load values 0..120 with ld_valid held high -> 121 writes to addresses 0..120 in consecutive cycles; ld_done pulses once; a storage backdoor read matches.
2. Weights all +1, bias 0, features all +2 with feat_valid held high -> res_data=240, res_class=1; res_valid exactly 2 cycles after the last feature edge.
3. Weights -256, features -256, bias 255 -> res_data=7864575, class 1. Features 255, bias -256 -> res_data=-7833856, class 0; no overflow in either case.
4. Scenario 2 stimulus with random feat_valid bubbles (about 30%) -> res_data=240; mem_addr and acc held during each bubble.
5. ld_start and cmp_start asserted in the same cycle -> LOAD entered, no compute. cmp_start or ld_start during LOAD/COMPUTE -> ignored and the running operation completes unchanged.
6. rst asserted at feature 50 of a compute -> next cycle busy=0 and all outputs 0; res_valid never pulses. A following full compute returns the correct score (240 with scenario 2 data).

Source files
------------

// File: rtl/svm_pkg.sv
// Shared constants and state encoding for the SVM coefficient-storage MAC sequencer.
package svm_pkg;

    localparam int DATA_W  = 9;
    localparam int ADDR_W  = 8;
    localparam int VEC_LEN = 120;
    localparam int DEPTH   = VEC_LEN + 1;
    localparam int ACC_W   = 25;

    localparam logic [ADDR_W-1:0] BIAS_ADDR   = ADDR_W'(VEC_LEN);
    localparam logic [ADDR_W-1:0] LAST_W_ADDR = ADDR_W'(VEC_LEN - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        COMPUTE = 3'd2,
        BIAS    = 3'd3,
        DONE    = 3'd4
    } state_e;

endpackage

// File: rtl/svm_mac_sequencer_mac.sv
// Signed multiply-accumulate; bias_en adds the sign-extended coefficient alone.
module svm_mac
    import svm_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     en,
    input  logic                     bias_en,
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    output logic signed [ACC_W-1:0]  acc_next
);

    logic signed [2*DATA_W-1:0] a_ext_s;
    logic signed [2*DATA_W-1:0] b_ext_s;
    logic signed [2*DATA_W-1:0] prod_s;
    logic signed [ACC_W-1:0]    acc_q;
    logic signed [ACC_W-1:0]    acc_d;

    // Product of two 9-bit signed values always fits in 18 signed bits.
    assign a_ext_s  = {{DATA_W{a[DATA_W-1]}}, a};
    assign b_ext_s  = {{DATA_W{b[DATA_W-1]}}, b};
    assign prod_s   = a_ext_s * b_ext_s;
    assign acc_next = acc_d;

    // Next accumulator value
    always_comb begin
        acc_d = acc_q;
        if (clr) begin
            acc_d = {ACC_W{1'b0}};
        end else if (bias_en) begin
            acc_d = acc_q + {{(ACC_W-DATA_W){a[DATA_W-1]}}, a};
        end else if (en) begin
            acc_d = acc_q + {{(ACC_W-2*DATA_W){prod_s[2*DATA_W-1]}}, prod_s};
        end else begin
            acc_d = acc_q;
        end
    end

    // Accumulator register
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= {ACC_W{1'b0}};
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/svm_mac_sequencer.sv
// Owns the coefficient storage: loads weights+bias from the host, then scores a feature vector.
module svm_mac_sequencer
    import svm_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_start,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    output logic              ld_done,
    input  logic              cmp_start,
    input  logic              feat_valid,
    input  logic [DATA_W-1:0] feat_data,
    output logic              feat_ready,
    output logic              res_valid,
    output logic [ACC_W-1:0]  res_data,
    output logic              res_class,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  ptr_q, ptr_d;
    logic               ld_done_q, ld_done_d;
    logic               res_valid_q, res_valid_d;
    logic [ACC_W-1:0]   res_data_q, res_data_d;
    logic               res_class_q, res_class_d;
    logic               busy_q, busy_d;
    logic               mac_clr_s, mac_en_s, mac_bias_en_s;
    logic signed [ACC_W-1:0] acc_next_s;

    svm_mac u_mac (
        .clk      (clk),
        .rst      (rst),
        .clr      (mac_clr_s),
        .en       (mac_en_s),
        .bias_en  (mac_bias_en_s),
        .a        ($signed(mem_rdata)),
        .b        ($signed(feat_data)),
        .acc_next (acc_next_s)
    );

    assign ld_done   = ld_done_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_class = res_class_q;
    assign busy      = busy_q;

    // Next-state, pointer and storage-port mux
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        ld_done_d     = 1'b0;
        res_valid_d   = 1'b0;
        res_data_d    = res_data_q;
        res_class_d   = res_class_q;
        mac_clr_s     = 1'b0;
        mac_en_s      = 1'b0;
        mac_bias_en_s = 1'b0;
        ld_ready      = 1'b0;
        feat_ready    = 1'b0;
        mem_addr      = {ADDR_W{1'b0}};
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_wdata     = {DATA_W{1'b0}};
        case (state_q)
            IDLE: begin
                if (ld_start) begin
                    state_d = LOAD;
                    ptr_d   = {ADDR_W{1'b0}};
                end else if (cmp_start) begin
                    state_d   = COMPUTE;
                    ptr_d     = {ADDR_W{1'b0}};
                    mac_clr_s = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                ld_ready  = 1'b1;
                mem_addr  = ptr_q;
                mem_wdata = ld_data;
                mem_write = ld_valid;
                if (ld_valid) begin
                    ptr_d = ptr_q + 8'd1;
                    if (ptr_q == BIAS_ADDR) begin
                        state_d   = IDLE;
                        ld_done_d = 1'b1;
                    end else begin
                        state_d = LOAD;
                    end
                end else begin
                    state_d = LOAD;
                end
            end
            COMPUTE: begin
                mem_read   = 1'b1;
                mem_addr   = ptr_q;
                feat_ready = 1'b1;
                if (feat_valid) begin
                    mac_en_s = 1'b1;
                    ptr_d    = ptr_q + 8'd1;
                    if (ptr_q == LAST_W_ADDR) begin
                        state_d = BIAS;
                    end else begin
                        state_d = COMPUTE;
                    end
                end else begin
                    state_d = COMPUTE;
                end
            end
            BIAS: begin
                // Result is captured from the MAC's next value so it is visible during DONE.
                mem_read      = 1'b1;
                mem_addr      = BIAS_ADDR;
                mac_bias_en_s = 1'b1;
                res_valid_d   = 1'b1;
                res_data_d    = acc_next_s;
                res_class_d   = ~acc_next_s[ACC_W-1];
                state_d       = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= {ADDR_W{1'b0}};
            ld_done_q   <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= {ACC_W{1'b0}};
            res_class_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            ld_done_q   <= ld_done_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_class_q <= res_class_d;
            busy_q      <= busy_d;
        end
    end

endmodule

// File: tb/tb_svm_mac_sequencer.sv
// Scoreboard bench: stimulus tasks queue expected writes/scores, a negedge monitor checks them.
module tb_svm_mac_sequencer;

    logic        clk;
    logic        rst;
    logic        ld_start, ld_valid, ld_ready, ld_done;
    logic [8:0]  ld_data;
    logic        cmp_start, feat_valid, feat_ready;
    logic [8:0]  feat_data;
    logic        res_valid, res_class, busy;
    logic [24:0] res_data;
    logic [7:0]  mem_addr;
    logic        mem_read, mem_write;
    logic [8:0]  mem_wdata, mem_rdata;

    logic [8:0]  store [0:120];

    typedef struct { int addr; int data; } wr_t;
    wr_t     wr_q[$];
    longint  res_q[$];

    int coef_next [0:120];
    int feat_next [0:119];
    int w_ref     [0:120];
    int checks = 0;
    int errors = 0;
    int ld_done_cnt = 0;
    int loads = 0;

    svm_mac_sequencer dut (
        .clk(clk), .rst(rst),
        .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data),
        .ld_ready(ld_ready), .ld_done(ld_done),
        .cmp_start(cmp_start), .feat_valid(feat_valid), .feat_data(feat_data),
        .feat_ready(feat_ready), .res_valid(res_valid), .res_data(res_data),
        .res_class(res_class), .busy(busy),
        .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Storage instance: registered write, combinational read
    always @(posedge clk) begin
        if (mem_write && mem_addr <= 8'd120) store[mem_addr] <= mem_wdata;
    end
    assign mem_rdata = (mem_addr <= 8'd120) ? store[mem_addr] : 9'd0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic longint model_score();
        longint s = 0;
        for (int i = 0; i < 120; i++) s += longint'(w_ref[i]) * longint'(feat_next[i]);
        return s + longint'(w_ref[120]);
    endfunction

    // Monitor: pops expectations whenever the DUT writes storage or presents a score
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_write) begin
                if (wr_q.size() == 0) begin
                    chk("unexpected_write", 1, 0);
                end else begin
                    wr_t e;
                    e = wr_q.pop_front();
                    chk("wr_addr", longint'(mem_addr), e.addr);
                    chk("wr_data", longint'($signed(mem_wdata)), e.data);
                end
            end
            if (res_valid) begin
                if (res_q.size() == 0) begin
                    chk("unexpected_res_valid", 1, 0);
                end else begin
                    longint e;
                    e = res_q.pop_front();
                    chk("res_data", longint'($signed(res_data)), e);
                    chk("res_class", longint'(res_class), (e >= 0) ? 1 : 0);
                end
            end
            if (mem_read && mem_write) chk("rd_wr_exclusive", 1, 0);
            if (ld_done) ld_done_cnt++;
        end
    end

    task automatic do_load(input int bub_pct, input bit both_start, input bit poke_cmp);
        int i, cyc, done0;
        done0 = ld_done_cnt;
        @(posedge clk); #1;
        ld_start = 1'b1; cmp_start = both_start;
        @(posedge clk); #1;
        ld_start = 1'b0; cmp_start = 1'b0;
        if (both_start) begin
            chk("both_start_ld_ready", longint'(ld_ready), 1);
            chk("both_start_feat_ready", longint'(feat_ready), 0);
            chk("both_start_busy", longint'(busy), 1);
        end
        i = 0; cyc = 0;
        while (i <= 120 && cyc < 3000) begin
            ld_valid  = ($urandom_range(99) >= bub_pct);
            ld_data   = 9'(coef_next[i]);
            cmp_start = poke_cmp && (i == 40);
            if (ld_valid) wr_q.push_back('{addr: i, data: coef_next[i]});
            @(posedge clk); #1;
            if (ld_valid) begin
                w_ref[i] = coef_next[i];
                i++;
            end
            cyc++;
        end
        ld_valid = 1'b0; cmp_start = 1'b0;
        if (cyc >= 3000) chk("load_timeout", 1, 0);
        if (bub_pct == 0) chk("load_cycles", cyc, 121);
        loads++;
        @(posedge clk); #1;
        chk("ld_done_once", ld_done_cnt - done0, 1);
        chk("busy_after_load", longint'(busy), 0);
    endtask

    task automatic do_compute(input int bub_pct, input bit poke_ld, input int abort_at);
        int i, cyc;
        @(posedge clk); #1;
        cmp_start = 1'b1;
        @(posedge clk); #1;
        cmp_start = 1'b0;
        if (abort_at < 0) res_q.push_back(model_score());
        i = 0; cyc = 0;
        while (i < 120 && cyc < 3000) begin
            chk("cmp_mem_addr", longint'(mem_addr), i);
            chk("cmp_feat_ready", longint'(feat_ready & mem_read), 1);
            if (i == abort_at) begin
                rst = 1'b1; feat_valid = 1'b0;
                @(posedge clk); #1;
                chk("abort_busy", longint'(busy), 0);
                chk("abort_outputs", longint'({ld_ready, ld_done, feat_ready, res_valid,
                    res_class, mem_read, mem_write}), 0);
                chk("abort_res_data", longint'(res_data), 0);
                chk("abort_mem_bus", longint'({mem_addr, mem_wdata}), 0);
                rst = 1'b0;
                return;
            end
            feat_valid = ($urandom_range(99) >= bub_pct);
            feat_data  = 9'(feat_next[i]);
            ld_start   = poke_ld && (i == 60);
            @(posedge clk); #1;
            if (feat_valid) i++;
            cyc++;
        end
        feat_valid = 1'b0; ld_start = 1'b0;
        if (cyc >= 3000) chk("compute_timeout", 1, 0);
        chk("bias_cycle_res_valid", longint'(res_valid), 0);
        chk("bias_cycle_addr", longint'(mem_addr), 120);
        @(posedge clk); #1;
        chk("latency_res_valid", longint'(res_valid), 1);
        @(posedge clk); #1;
        chk("res_valid_one_cycle", longint'(res_valid), 0);
        chk("busy_after_compute", longint'(busy), 0);
    endtask

    initial begin
        rst = 1'b1; ld_start = 1'b0; ld_valid = 1'b0; ld_data = 9'd0;
        cmp_start = 1'b0; feat_valid = 1'b0; feat_data = 9'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", longint'(busy), 0);
        chk("reset_flags", longint'({ld_ready, ld_done, feat_ready, res_valid, res_class}), 0);
        chk("reset_res_data", longint'(res_data), 0);
        chk("reset_mem", longint'({mem_addr, mem_read, mem_write, mem_wdata}), 0);
        rst = 1'b0;

        // Sequential load, backdoor readback
        for (int k = 0; k <= 120; k++) coef_next[k] = k;
        do_load(0, 1'b0, 1'b0);
        for (int k = 0; k <= 120; k++) chk("backdoor", longint'($signed(store[k])), k);

        // Extreme magnitudes, both signs
        for (int k = 0; k < 120; k++) coef_next[k] = -256;
        coef_next[120] = 255;
        do_load(0, 1'b0, 1'b0);
        for (int k = 0; k < 120; k++) feat_next[k] = -256;
        do_compute(0, 1'b0, -1);
        coef_next[120] = -256;
        do_load(0, 1'b0, 1'b0);
        for (int k = 0; k < 120; k++) feat_next[k] = 255;
        do_compute(0, 1'b0, -1);

        // Simultaneous starts load; a cmp_start mid-load and an ld_start mid-compute are ignored
        for (int k = 0; k < 120; k++) coef_next[k] = 1;
        coef_next[120] = 0;
        do_load(0, 1'b1, 1'b1);
        for (int k = 0; k < 120; k++) feat_next[k] = 2;
        chk("model_240", model_score(), 240);
        do_compute(0, 1'b1, -1);

        // Feature bubbles, then a reset at feature 50 and a clean rerun
        do_compute(30, 1'b0, -1);
        do_compute(0, 1'b0, 50);
        do_compute(0, 1'b0, -1);

        // Random coefficients and features
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k <= 120; k++) coef_next[k] = int'($urandom_range(511)) - 256;
            for (int k = 0; k < 120; k++) feat_next[k] = int'($urandom_range(511)) - 256;
            do_load(20, 1'b0, 1'b0);
            do_compute(30, 1'b0, -1);
        end

        repeat (4) @(posedge clk);
        #1;
        chk("res_queue_drained", res_q.size(), 0);
        chk("wr_queue_drained", wr_q.size(), 0);
        chk("ld_done_total", ld_done_cnt, loads);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
